// File: rtl/alu_issue_ctrl.sv
// Issue stage for the 16-bit combinational ALU: command FIFO, operand drivers, settle timer, result capture.
// Optional accumulator forwarding of operand A is enabled by defining ALU_ACC_FWD_EN.
module alu_issue_ctrl #(
    parameter int unsigned DW         = 16,
    parameter int unsigned OPW        = 3,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned SETTLE     = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           cmd_valid,
    output logic           cmd_ready,
    input  logic [OPW-1:0] cmd_opc,
    input  logic [DW-1:0]  cmd_a,
    input  logic [DW-1:0]  cmd_b,
    input  logic           cmd_c,
`ifdef ALU_ACC_FWD_EN
    input  logic           cmd_use_acc,
`endif
    output logic [DW-1:0]  ina,
    output logic [DW-1:0]  inb,
    output logic           inc,
    output logic [OPW-1:0] opc,
    input  logic [DW-1:0]  w,
    input  logic           zer,
    input  logic           neg,
    output logic           res_valid,
    input  logic           res_ready,
    output logic [DW-1:0]  res_w,
    output logic           res_zer,
    output logic           res_neg,
    output logic [DW-1:0]  acc,
    output logic           busy
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    typedef struct packed {
`ifdef ALU_ACC_FWD_EN
        logic           use_acc;
`endif
        logic [OPW-1:0] opc;
        logic [DW-1:0]  a;
        logic [DW-1:0]  b;
        logic           c;
    } cmd_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [SW-1:0]   r_settle, w_settle_nxt;
    logic            w_pop, w_capture, w_push;
    cmd_t            r_mem [FIFO_DEPTH];
    cmd_t            w_cmd_in, w_head;
    logic [PW-1:0]   r_wr_ptr, r_rd_ptr;
    logic [CW-1:0]   r_count, w_count_nxt;
    logic            r_cmd_ready, r_busy, r_res_valid;
    logic [DW-1:0]   r_ina, r_inb, r_res_w, r_acc, w_op_a;
    logic            r_inc, r_res_zer, r_res_neg;
    logic [OPW-1:0]  r_opc;

    always_comb begin
        w_cmd_in     = '0;
        w_cmd_in.opc = cmd_opc;
        w_cmd_in.a   = cmd_a;
        w_cmd_in.b   = cmd_b;
        w_cmd_in.c   = cmd_c;
`ifdef ALU_ACC_FWD_EN
        w_cmd_in.use_acc = cmd_use_acc;
`endif
    end

    assign w_push      = cmd_valid & r_cmd_ready;
    assign w_head      = r_mem[r_rd_ptr];
    assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);

`ifdef ALU_ACC_FWD_EN
    // acc already holds the previous result: a pop only follows the HOLD handshake
    assign w_op_a = w_head.use_acc ? r_acc : w_head.a;
`else
    assign w_op_a = w_head.a;
`endif

    // Command storage; contents need no reset since occupancy gates every read
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_cmd_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_cmd_ready <= 1'b1;
            r_busy      <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            r_count     <= w_count_nxt;
            r_cmd_ready <= (w_count_nxt != CW'(FIFO_DEPTH));
            r_busy      <= (w_state_nxt != S_IDLE) || (w_count_nxt != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_settle <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_settle <= w_settle_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_settle_nxt = r_settle;
        w_pop        = 1'b0;
        w_capture    = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (r_count != '0) begin
                    w_pop        = 1'b1;
                    w_settle_nxt = '0;
                    w_state_nxt  = S_DRIVE;
                end
            end
            S_DRIVE: begin
                if (r_settle == SW'(SETTLE - 1)) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_HOLD;
                end else begin
                    w_settle_nxt = r_settle + SW'(1);
                end
            end
            S_HOLD: begin
                if (res_ready) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Operand drivers hold until the next pop; result registers hold until the next capture
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ina       <= '0;
            r_inb       <= '0;
            r_inc       <= 1'b0;
            r_opc       <= '0;
            r_res_w     <= '0;
            r_res_zer   <= 1'b0;
            r_res_neg   <= 1'b0;
            r_acc       <= '0;
            r_res_valid <= 1'b0;
        end else begin
            if (w_pop) begin
                r_ina <= w_op_a;
                r_inb <= w_head.b;
                r_inc <= w_head.c;
                r_opc <= w_head.opc;
            end
            if (w_capture) begin
                r_res_w     <= w;
                r_res_zer   <= zer;
                r_res_neg   <= neg;
                r_acc       <= w;
                r_res_valid <= 1'b1;
            end else if ((r_state == S_HOLD) && res_ready) begin
                r_res_valid <= 1'b0;
            end
        end
    end

    assign cmd_ready = r_cmd_ready;
    assign busy      = r_busy;
    assign ina       = r_ina;
    assign inb       = r_inb;
    assign inc       = r_inc;
    assign opc       = r_opc;
    assign res_valid = r_res_valid;
    assign res_w     = r_res_w;
    assign res_zer   = r_res_zer;
    assign res_neg   = r_res_neg;
    assign acc       = r_acc;

endmodule
